// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter for the w line: a word goes out MSB-first,
// optionally repeated, with GAP idle-zero cycles after every copy.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    parameter int REP_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           din,
    input  logic [$clog2(WIDTH+1)-1:0] nbits,
    input  logic [REP_W-1:0]           rep,
    input  logic                       valid,
    output logic                       ready,
    output logic                       w,
    output logic                       busy,
    output logic                       done
);

    localparam int NW = $clog2(WIDTH+1);
    localparam int GW = (GAP > 0) ? $clog2(GAP+1) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAPS, DONE} state_t;

    state_t           state, state_nxt;
    logic [NW-1:0]    n_in, n_q, cnt;
    logic [WIDTH-1:0] word, sreg;
    logic [GW-1:0]    gcnt;
    logic [REP_W-1:0] rcnt;
    logic             take, last_bit, last_gap, copy_end, reload;
    logic             w_nxt, done_nxt;

    assign n_in = (nbits == '0 || nbits > NW'(WIDTH)) ? NW'(WIDTH) : nbits;

    // done is registered one cycle behind the DONE state, so the
    // handshake stays closed until the pulse has gone.
    assign ready = (state == IDLE) && !done;
    assign busy  = (state != IDLE) || done;
    assign take  = valid && ready;

    assign last_bit = (state == SHIFT) && (cnt == NW'(1));
    assign last_gap = (state == GAPS) && (gcnt == GW'(1));
    assign copy_end = (GAP == 0) ? last_bit : last_gap;
    assign reload   = copy_end && (rcnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            w     <= 1'b0;
            done  <= 1'b0;
            n_q   <= '0;
            cnt   <= '0;
            word  <= '0;
            sreg  <= '0;
            gcnt  <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            w     <= w_nxt;
            done  <= done_nxt;
            if (take) begin
                n_q  <= n_in;
                cnt  <= n_in;
                rcnt <= rep;
                word <= din << (NW'(WIDTH) - n_in);
                sreg <= din << (NW'(WIDTH) - n_in);
            end else if (reload) begin
                sreg <= word;
                cnt  <= n_q;
                rcnt <= rcnt - REP_W'(1);
            end else if (state == SHIFT) begin
                if (!last_bit) begin
                    sreg <= sreg << 1;
                    cnt  <= cnt - NW'(1);
                end else begin
                    gcnt <= GW'(GAP);
                end
            end else if (state == GAPS && !last_gap) begin
                gcnt <= gcnt - GW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (take) state_nxt = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    if (GAP > 0)      state_nxt = GAPS;
                    else if (reload)  state_nxt = SHIFT;
                    else              state_nxt = DONE;
                end
            end
            GAPS:  if (last_gap) state_nxt = reload ? SHIFT : DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_nxt    = 1'b0;
        done_nxt = 1'b0;
        unique case (state)
            SHIFT:   w_nxt    = sreg[WIDTH-1];
            DONE:    done_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: GAP=2 instance for most steps,
// a GAP=0 instance for back-to-back repeats.
module tb_serial_pattern_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [3:0] nbits;
    logic [3:0] rep;
    logic       valid, ready, w, busy, done;
    logic [7:0] din0;
    logic [3:0] nbits0;
    logic [3:0] rep0;
    logic       valid0, ready0, w0, busy0, done0;

    int nerr = 0;
    int nchk = 0;

    serial_pattern_tx #(.WIDTH(8), .GAP(2), .REP_W(4)) u_dut (
        .clk(clk), .rst(rst), .din(din), .nbits(nbits), .rep(rep),
        .valid(valid), .ready(ready), .w(w), .busy(busy), .done(done)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(0), .REP_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .din(din0), .nbits(nbits0), .rep(rep0),
        .valid(valid0), .ready(ready0), .w(w0), .busy(busy0), .done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] nb,
                        input logic [3:0] r);
        int t;
        t = 0;
        @(negedge clk);
        while (!ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", ready, 1'b1);
        din   = d;
        nbits = nb;
        rep   = r;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic expect_seq(input string tag, input logic [15:0] bits,
                              input int len);
        for (int i = 0; i < len; i++) begin
            step();
            chk(tag, w, bits[len-1-i]);
            chk({tag, "_nodone"}, done, 1'b0);
        end
    endtask

    initial begin
        logic [8:0] pat0;
        logic [4:0] pat1;
        rst = 1'b0; valid = 1'b1; din = 8'hFF; nbits = 4'd8; rep = '0;
        valid0 = 1'b0; din0 = '0; nbits0 = '0; rep0 = '0;

        // reset held with valid high: nothing accepted
        step(); step();
        chk("rst_w", w, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        valid = 1'b0;
        rst = 1'b1;
        step();
        chk("rel_busy", busy, 1'b0);
        chk("rel_ready", ready, 1'b1);

        // din=06 nbits=3: 1,1,0 then two gap zeros
        send(8'h06, 4'd3, 4'd0);
        chk("t1_ready0", ready, 1'b0);
        chk("t1_busy", busy, 1'b1);
        expect_seq("t1_w", 16'b11000, 5);
        step();
        chk("t1_done", done, 1'b1);
        chk("t1_done_ready", ready, 1'b0);
        step();
        chk("t1_done_end", done, 1'b0);
        chk("t1_idle_ready", ready, 1'b1);
        chk("t1_idle_busy", busy, 1'b0);

        // nbits=0 and nbits=12 both clamp to 8
        send(8'hA5, 4'd0, 4'd0);
        expect_seq("n0_w", 16'b1010010100, 10);
        step();
        chk("n0_done", done, 1'b1);
        send(8'hA5, 4'd12, 4'd0);
        expect_seq("n12_w", 16'b1010010100, 10);
        step();
        chk("n12_done", done, 1'b1);

        // GAP=0 instance: three back-to-back copies of 101
        pat0 = 9'b101101101;
        @(negedge clk);
        din0 = 8'h05; nbits0 = 4'd3; rep0 = 4'd2; valid0 = 1'b1;
        @(posedge clk);
        #1 valid0 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("g0_w", w0, pat0[8-i]);
            chk("g0_busy", busy0, 1'b1);
            chk("g0_nodone", done0, 1'b0);
        end
        step();
        chk("g0_done", done0, 1'b1);
        step();
        chk("g0_done_end", done0, 1'b0);
        chk("g0_ready", ready0, 1'b1);

        // valid held high, din toggling while busy
        pat1 = 5'b11000;
        @(negedge clk);
        din = 8'h06; nbits = 4'd3; rep = 4'd0; valid = 1'b1;
        @(posedge clk);
        #1 din = 8'hF9; nbits = 4'd8; rep = 4'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_w", w, pat1[4-i]);
            din = ~din;
        end
        step();
        chk("hold_done", done, 1'b1);
        chk("hold_done_busy", busy, 1'b1);
        din = 8'h02; nbits = 4'd2; rep = 4'd0;
        step();
        chk("hold_noacc_busy", busy, 1'b0);
        chk("hold_idle_ready", ready, 1'b1);
        step();
        chk("hold_acc_busy", busy, 1'b1);
        chk("hold_acc_ready", ready, 1'b0);
        valid = 1'b0;
        expect_seq("hold2_w", 16'b1000, 4);
        step();
        chk("hold2_done", done, 1'b1);

        // reset mid-word
        send(8'hFF, 4'd8, 4'd0);
        expect_seq("mid_w", 16'b11, 2);
        #2 rst = 1'b0;
        #1;
        chk("mid_w0", w, 1'b0);
        chk("mid_ready", ready, 1'b1);
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_after_done", done, 1'b0);
            chk("mid_after_w", w, 1'b0);
            chk("mid_after_ready", ready, 1'b1);
        end
        send(8'h81, 4'd8, 4'd0);
        expect_seq("post_w", 16'b1000000100, 10);
        step();
        chk("post_done", done, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
